keypad_matrix_scanner: RTL and testbench

4x4 matrix keypad input scanner. It is the input-direction counterpart of the team's 8x8 dot-matrix row-scan display driver. It drives one keypad column low at a time on a divided scan tick and samples the row lines. It debounces over whole scans and emits a one-cycle key event with a 4-bit key code for downstream display and control logic.

---
 rtl/keypad_matrix_scanner_if.sv | 25 ++
 rtl/keypad_matrix_scanner.sv | 207 ++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_scanner_if.sv
// Signal bundle between the 4x4 keypad scanner and the keypad/consumer side.
// The scanner owns column drive and the key event outputs; the pad owns the rows.
interface keypad_matrix_scanner_if;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        input  key_row,
        output key_col,
        output key_valid,
        output key_code,
        output key_held
    );

    modport slave (
        output key_row,
        input  key_col,
        input  key_valid,
        input  key_code,
        input  key_held
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: one active-low column per divided tick, whole-scan
// classification and a press/release debounce FSM producing one event per press.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 2500,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    keypad_matrix_scanner_if.master kp
);

    localparam int         DIV_W  = $clog2(SCAN_DIV);
    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= DB_MAX) ? DB_MAX : v + 4'd1;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [3:0]       col_drive;
    logic             col_tick;
    logic             scan_tick;

    logic [3:0]       row_sync_p0;
    logic [3:0]       row_sync_p1;
    logic [11:0]      scan_buf;

    logic [15:0]      pressed_map;
    logic [4:0]       hit_cnt;
    logic [3:0]       hit_code;
    logic             is_none;
    logic             is_single;

    state_t           state, state_nxt;
    logic [3:0]       cand, cand_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [3:0]       rcnt, rcnt_nxt;
    logic             accept;
    logic             release_done;

    logic             valid_q;
    logic [3:0]       code_q, code_nxt;
    logic             held_q, held_nxt;

    // Stage p0/p1: two-flop synchroniser for the asynchronous row lines
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_sync_p0 <= 4'b1111;
            row_sync_p1 <= 4'b1111;
        end else begin
            row_sync_p0 <= kp.key_row;
            row_sync_p1 <= row_sync_p0;
        end
    end

    assign col_tick  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign scan_tick = col_tick && (col_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt   <= '0;
            col_idx   <= 2'd0;
            col_drive <= 4'b1110;
        end else if (col_tick) begin
            div_cnt   <= '0;
            col_idx   <= col_idx + 2'd1;
            col_drive <= {col_drive[2:0], col_drive[3]};
        end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
        end
    end

    // Columns 0..2 are stored; column 3 is taken live on the end-of-scan tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_buf <= '0;
        end else if (col_tick) begin
            case (col_idx)
                2'd0:    scan_buf[3:0]  <= ~row_sync_p1;
                2'd1:    scan_buf[7:4]  <= ~row_sync_p1;
                2'd2:    scan_buf[11:8] <= ~row_sync_p1;
                default: ;
            endcase
        end
    end

    // Bit index of pressed_map equals col*4 + row, i.e. the key code
    assign pressed_map = {~row_sync_p1, scan_buf};

    always_comb begin
        hit_cnt  = 5'd0;
        hit_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pressed_map[i]) begin
                hit_cnt  = hit_cnt + 5'd1;
                hit_code = 4'(i);
            end
        end
    end

    assign is_none   = (hit_cnt == 5'd0);
    assign is_single = (hit_cnt == 5'd1);

    // FSM state register together with the registered key outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cand    <= 4'd0;
            cnt     <= 4'd0;
            rcnt    <= 4'd0;
            valid_q <= 1'b0;
            code_q  <= 4'd0;
            held_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cand    <= cand_nxt;
            cnt     <= cnt_nxt;
            rcnt    <= rcnt_nxt;
            valid_q <= accept;
            code_q  <= code_nxt;
            held_q  <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        rcnt_nxt  = rcnt;
        if (scan_tick) begin
            case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_nxt  = hit_code;
                        cnt_nxt   = 4'd1;
                        state_nxt = (DB_MAX == 4'd1) ? PRESSED : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (is_single && (hit_code == cand)) begin
                        cnt_nxt = sat_inc(cnt);
                        if (sat_inc(cnt) >= DB_MAX) begin
                            state_nxt = PRESSED;
                        end
                    end else if (is_single) begin
                        cand_nxt = hit_code;
                        cnt_nxt  = 4'd1;
                    end else begin
                        cnt_nxt   = 4'd0;
                        state_nxt = IDLE;
                    end
                end
                PRESSED: begin
                    if (!(is_single && (hit_code == cand))) begin
                        if (is_none) begin
                            rcnt_nxt  = 4'd1;
                            state_nxt = (DB_MAX == 4'd1) ? IDLE : RELEASE;
                        end else begin
                            rcnt_nxt  = 4'd0;
                            state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (is_none) begin
                        rcnt_nxt = sat_inc(rcnt);
                        if (sat_inc(rcnt) >= DB_MAX) begin
                            state_nxt = IDLE;
                        end
                    end else if (is_single && (hit_code == cand)) begin
                        state_nxt = PRESSED;
                    end else begin
                        rcnt_nxt = 4'd0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A PRESSED entry from IDLE/DEBOUNCE is an accept; RELEASE->PRESSED is not
    always_comb begin
        accept       = ((state == IDLE) || (state == DEBOUNCE)) && (state_nxt == PRESSED);
        release_done = ((state == PRESSED) || (state == RELEASE)) && (state_nxt == IDLE);
        code_nxt     = accept ? cand_nxt : code_q;
        held_nxt     = held_q;
        if (accept) begin
            held_nxt = 1'b1;
        end else if (release_done) begin
            held_nxt = 1'b0;
        end
    end

    assign kp.key_col   = col_drive;
    assign kp.key_valid = valid_q;
    assign kp.key_code  = code_q;
    assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: a behavioural keypad drives the rows,
// stimulus queues expected key codes and a monitor checks every key_valid pulse.
module tb_keypad_matrix_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  row_drive;
    logic        prev_valid = 1'b0;
    int          exp_code;
    int          exp_q[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    keypad_matrix_scanner_if kp();

    keypad_matrix_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kp(kp)
    );

    // Pressed key (c,r) pulls row r low while column c is driven low
    always_comb begin
        row_drive = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!kp.key_col[c] && pressed[c*4+r]) row_drive[r] = 1'b0;
            end
        end
    end
    assign kp.key_row = row_drive;

    always @(posedge clk) begin
        #1;
        if (kp.key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_key_valid actual_code=%0d required=no_event", kp.key_code);
            end else begin
                exp_code = exp_q.pop_front();
                if (kp.key_code !== 4'(exp_code) || kp.key_held !== 1'b1) begin
                    failures++;
                    $display("FAIL key_event actual_code=%0d held=%0b required_code=%0d held=1",
                             kp.key_code, kp.key_held, exp_code);
                end
            end
            if (prev_valid) begin
                checks++;
                failures++;
                $display("FAIL valid_consecutive actual=1 required=0");
            end
        end
        prev_valid = kp.key_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic next_scan_start();
        int         n;
        logic [3:0] last;
        n    = 0;
        last = kp.key_col;
        forever begin
            @(negedge clk);
            if (kp.key_col == 4'b1110 && last == 4'b0111) break;
            last = kp.key_col;
            n++;
            if (n > 100) begin
                $display("FAIL scan_start_timeout actual=no_wrap required=wrap_within_100_cycles");
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
                $fatal(1, "scan wrap timeout");
            end
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n) next_scan_start();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_key_col", kp.key_col, 4'b1110);
        check("rst_key_valid", kp.key_valid, 1'b0);
        check("rst_key_code", kp.key_code, 4'd0);
        check("rst_key_held", kp.key_held, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "global timeout");
    end

    initial begin
        // Test 1: idle column rotation, outputs quiet
        pulse_reset();
        for (int n = 1; n < 200; n++) begin
            logic [3:0] exp_col;
            @(negedge clk);
            exp_col = ~(4'b0001 << ((n / 4) % 4));
            check("idle_col", kp.key_col, exp_col);
            check("idle_held_code", {kp.key_held, kp.key_code}, 5'd0);
        end

        // Test 2: key 6 held 10 scans then released
        next_scan_start();
        pressed = 16'h0040;
        exp_q.push_back(6);
        wait_scans(2);
        check("t2_not_early", exp_q.size(), 1);
        wait_scans(1);
        check("t2_event_seen", exp_q.size(), 0);
        check("t2_held", kp.key_held, 1'b1);
        wait_scans(7);
        pressed = 16'h0000;
        wait_scans(2);
        check("t2_held_during_release", kp.key_held, 1'b1);
        wait_scans(1);
        check("t2_released", kp.key_held, 1'b0);
        check("t2_code_kept", kp.key_code, 4'd6);

        // Test 3: alternating one-scan bounce
        for (int i = 0; i < 5; i++) begin
            pressed = 16'h0040;
            wait_scans(1);
            pressed = 16'h0000;
            wait_scans(1);
        end
        check("t3_no_event", exp_q.size(), 0);
        check("t3_held", kp.key_held, 1'b0);

        // Test 4: keys 0 and 15 together, then 15 alone
        pressed = 16'h8001;
        wait_scans(5);
        check("t4_multi_held", kp.key_held, 1'b0);
        pressed = 16'h8000;
        exp_q.push_back(15);
        wait_scans(2);
        check("t4_not_early", exp_q.size(), 1);
        wait_scans(1);
        check("t4_event_seen", exp_q.size(), 0);
        check("t4_code", kp.key_code, 4'd15);
        pressed = 16'h0000;
        wait_scans(3);
        check("t4_released", kp.key_held, 1'b0);

        // Test 5: reset during debounce of key 9
        pressed = 16'h0200;
        wait_scans(2);
        pulse_reset();
        exp_q.push_back(9);
        wait_scans(2);
        check("t5_not_early", exp_q.size(), 1);
        check("t5_held_low", kp.key_held, 1'b0);
        wait_scans(1);
        check("t5_event_seen", exp_q.size(), 0);
        check("t5_code", kp.key_code, 4'd9);

        // Test 6: accepted key switched to another without release
        pressed = 16'h0000;
        wait_scans(3);
        check("t6_pre_release", kp.key_held, 1'b0);
        pressed = 16'h0040;
        exp_q.push_back(6);
        wait_scans(3);
        check("t6_first_event", exp_q.size(), 0);
        pressed = 16'h0200;
        wait_scans(6);
        check("t6_switch_held", kp.key_held, 1'b1);
        check("t6_switch_code", kp.key_code, 4'd6);
        pressed = 16'h0000;
        wait_scans(2);
        check("t6_release_pending", kp.key_held, 1'b1);
        wait_scans(1);
        check("t6_released", kp.key_held, 1'b0);
        pressed = 16'h0200;
        exp_q.push_back(9);
        wait_scans(3);
        check("t6_second_event", exp_q.size(), 0);
        check("t6_code", kp.key_code, 4'd9);
        check("t6_held", kp.key_held, 1'b1);

        repeat (20) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
